// File: rtl/cache_nway_tag_data_array_pkg.sv
`default_nettype none
// cache_pkg: shared state encoding, default geometry and replacement-state width helpers
// for cache_nway_tag_data_array.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  localparam int DEF_SETS   = 64;
  localparam int DEF_WAYS   = 2;
  localparam int DEF_TAG_W  = 23;
  localparam int DEF_DATA_W = 64;

  // Width of a way index; a direct-mapped cache still carries one (always zero) bit.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int plru_w(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

  function automatic int rr_w(input int ways);
    return way_w(ways);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_way_match.sv
`default_nettype none
// cache_way_match: parallel tag compare across all ways of one set; one-hot hit vector
// plus the encoded index of the lowest matching way.
module cache_way_match
  import cache_pkg::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int TAG_W = DEF_TAG_W,
  parameter int WAY_W = way_w(DEF_WAYS)
)(
  input  logic [WAYS-1:0][TAG_W-1:0] tags,
  input  logic [WAYS-1:0]            valids,
  input  logic [TAG_W-1:0]           tag,
  output logic [WAYS-1:0]            hit_vec,
  output logic [WAY_W-1:0]           hit_way
);

  for (genvar w = 0; w < WAYS; w++) begin : g_cmp
    assign hit_vec[w] = valids[w] && (tags[w] == tag);
  end

  // Descending scan so the lowest matching way is the one left standing.
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_nway_tag_data_array.sv
`default_nettype none
// cache_nway_tag_data_array: N-way set-associative tag/data array with lookup/refill controller.
// Define CACHE_LRU_EN for tree pseudo-LRU replacement; otherwise a per-set round-robin pointer is used.
module cache_nway_tag_data_array
  import cache_pkg::*;
#(
  parameter int SETS    = DEF_SETS,
  parameter int WAYS    = DEF_WAYS,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INDEX_W = $clog2(SETS),
  parameter int ADDR_W  = TAG_W + INDEX_W
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              refill_valid,
  output logic [ADDR_W-1:0] refill_addr,
  input  logic              refill_ack,
  input  logic [DATA_W-1:0] refill_data
);

  localparam int WAY_W = way_w(WAYS);
  localparam int LVLS  = $clog2(WAYS);
`ifdef CACHE_LRU_EN
  localparam int REPL_W = plru_w(WAYS);
`else
  localparam int REPL_W = rr_w(WAYS);
`endif

  state_t             state;
  logic               lat_wr;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [WAY_W-1:0]   victim_r;
  logic               victim_was_inv;

  logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];
  logic [DATA_W-1:0]  data_mem  [SETS][WAYS];
  logic [WAYS-1:0]    valid_mem [SETS];
  logic [REPL_W-1:0]  repl      [SETS];

  logic [INDEX_W-1:0]            idx;
  logic [TAG_W-1:0]              lat_tag;
  logic [WAYS-1:0][TAG_W-1:0]    set_tags;
  logic [WAYS-1:0]               hit_vec;
  logic [WAY_W-1:0]              hit_way;
  logic                          hit;
  logic [WAY_W-1:0]              repl_victim;
  logic [WAY_W-1:0]              victim;
  logic                          has_inv;
  logic                          refill_fire;

  assign idx         = lat_addr[INDEX_W-1:0];
  assign lat_tag     = lat_addr[ADDR_W-1:INDEX_W];
  assign hit         = |hit_vec;
  assign req_ready   = (state == ST_IDLE);
  assign refill_fire = (state == ST_REFILL) && refill_valid && refill_ack;

  always_comb begin
    for (int w = 0; w < WAYS; w++) set_tags[w] = tag_mem[idx][w];
  end

  cache_way_match #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_match (
    .tags    (set_tags),
    .valids  (valid_mem[idx]),
    .tag     (lat_tag),
    .hit_vec (hit_vec),
    .hit_way (hit_way)
  );

`ifdef CACHE_LRU_EN
  // Tree node n has children 2n+1 / 2n+2; a node bit of 1 steers the victim to the right subtree.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [REPL_W-1:0] bits);
    logic [7:0] b;
    logic [2:0] node;
    logic [2:0] way;
    b    = 8'(bits);
    node = '0;
    way  = '0;
    for (int l = 0; l < LVLS; l++) begin
      way  = {way[1:0], b[node]};
      node = 3'(2 * node + 1 + {2'b00, b[node]});
    end
    return WAY_W'(way);
  endfunction

  function automatic logic [REPL_W-1:0] plru_touch(input logic [REPL_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [7:0] b;
    logic [2:0] node;
    logic [2:0] wl;
    logic       dir;
    b    = 8'(bits);
    node = '0;
    wl   = 3'(way) << (3 - LVLS);
    for (int l = 0; l < LVLS; l++) begin
      dir     = wl[2];
      b[node] = ~dir;
      node    = 3'(2 * node + 1 + {2'b00, dir});
      wl      = wl << 1;
    end
    return REPL_W'(b);
  endfunction

  assign repl_victim = plru_victim(repl[idx]);
`else
  assign repl_victim = (WAYS == 1) ? '0 : WAY_W'(repl[idx]);
`endif

  always_comb begin
    victim  = repl_victim;
    has_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[idx][w]) begin
        victim  = WAY_W'(w);
        has_inv = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_rdata   <= '0;
      refill_valid <= 1'b0;
      refill_addr  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        repl[s]      <= '0;
      end
    end else begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_wr    <= req_wr;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_rdata <= lat_wr ? '0 : data_mem[idx][hit_way];
`ifdef CACHE_LRU_EN
            repl[idx]  <= plru_touch(repl[idx], hit_way);
`endif
            state      <= ST_IDLE;
          end else if (lat_wr) begin
            resp_valid <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            victim_r       <= victim;
            victim_was_inv <= has_inv;
            refill_valid   <= 1'b1;
            refill_addr    <= lat_addr;
            state          <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (refill_fire) begin
            valid_mem[idx][victim_r] <= 1'b1;
`ifdef CACHE_LRU_EN
            repl[idx] <= plru_touch(repl[idx], victim_r);
`else
            if (!victim_was_inv) repl[idx] <= (WAYS > 1) ? repl[idx] + 1'b1 : '0;
`endif
            resp_valid   <= 1'b1;
            resp_rdata   <= refill_data;
            refill_valid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone decide whether a line exists.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_LOOKUP && hit && lat_wr) data_mem[idx][hit_way] <= lat_wdata;
      if (refill_fire) begin
        tag_mem[idx][victim_r]  <= lat_tag;
        data_mem[idx][victim_r] <= refill_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_nway_tag_data_array.sv
`default_nettype none
// Scoreboard bench for cache_nway_tag_data_array at SETS=64, WAYS=2, TAG_W=23, DATA_W=64.
module tb_cache_nway_tag_data_array;

  localparam int ADDR_W = 29;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_wr = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [63:0]       req_wdata = '0;
  logic              refill_ack = 1'b0;
  logic [63:0]       refill_data = '0;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_hit;
  logic [63:0]       resp_rdata;
  logic              refill_valid;
  logic [ADDR_W-1:0] refill_addr;

  typedef struct packed {
    logic        hit;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   resps  = 0;

  always #5 clk = ~clk;

  cache_nway_tag_data_array dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_rdata   (resp_rdata),
    .refill_valid (refill_valid),
    .refill_addr  (refill_addr),
    .refill_ack   (refill_ack),
    .refill_data  (refill_data)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Response monitor: every response pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (resp_valid) begin
        resps++;
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_hit", {63'd0, resp_hit}, {63'd0, e.hit});
          chk("resp_rdata", resp_rdata, e.data);
        end
      end else begin
        chk("idle_resp_zero", resp_rdata | {63'd0, resp_hit}, 64'd0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [63:0] d,
                       input logic hold);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'd1, 64'd0);
    tick();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_refill(input logic [ADDR_W-1:0] a);
    int n;
    n = 0;
    while (!refill_valid && n < 20) begin
      tick();
      n++;
    end
    chk("refill_valid", {63'd0, refill_valid}, 64'd1);
    chk("refill_addr", 64'(refill_addr), 64'(a));
  endtask

  task automatic ack(input logic [63:0] d);
    refill_data = d;
    refill_ack  = 1'b1;
    tick();
    refill_ack  = 1'b0;
  endtask

  task automatic rd_miss(input logic [ADDR_W-1:0] a, input logic [63:0] d, input int delay);
    sb.push_back('{hit: 1'b0, data: d});
    issue(1'b0, a, 64'd0, 1'b0);
    wait_refill(a);
    tick(delay);
    ack(d);
    chk("refill_drop", {63'd0, refill_valid}, 64'd0);
    tick();
  endtask

  task automatic rd_hit(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    sb.push_back('{hit: 1'b1, data: d});
    issue(1'b0, a, 64'd0, 1'b0);
    @(negedge clk);
    chk("hit_not_early", {63'd0, resp_valid}, 64'd0);
    tick();
    @(negedge clk);
    chk("hit_latency", {63'd0, resp_valid}, 64'd1);
    chk("hit_no_refill", {63'd0, refill_valid}, 64'd0);
    tick();
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [63:0] d, input logic exp_hit);
    sb.push_back('{hit: exp_hit, data: 64'd0});
    issue(1'b1, a, d, 1'b0);
    tick(2);
    chk("write_no_refill", {63'd0, refill_valid}, 64'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  initial begin
    int r0;
    tick(3);
    reset = 1'b0;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_refill_valid", {63'd0, refill_valid}, 64'd0);
    chk("rst_refill_addr", 64'(refill_addr), 64'd0);

    // Cold miss, re-read hit, write hit, write miss without allocate.
    rd_miss(29'h0000005, 64'hA5, 2);
    rd_hit(29'h0000005, 64'hA5);
    wr(29'h0000005, 64'h1234, 1'b1);
    rd_hit(29'h0000005, 64'h1234);
    wr(29'h07F0005, 64'hBEEF, 1'b0);
    rd_miss(29'h07F0005, 64'h77, 0);

    // Replacement in set 5: tags 1, 2, touch tag 1, then tag 3.
    pulse_reset();
    rd_miss(29'h0000045, 64'h11, 1);
    rd_miss(29'h0000085, 64'h22, 1);
    rd_hit(29'h0000045, 64'h11);
    rd_miss(29'h00000C5, 64'h33, 1);
`ifdef CACHE_LRU_EN
    rd_hit(29'h0000045, 64'h11);
    rd_miss(29'h0000085, 64'h55, 0);
`else
    rd_hit(29'h0000085, 64'h22);
    rd_miss(29'h0000045, 64'h44, 0);
`endif

    // Reset in the middle of a refill abandons it and clears every line.
    issue(1'b0, 29'h0000105, 64'd0, 1'b0);
    wait_refill(29'h0000105);
    tick(2);
    r0 = resps;
    pulse_reset();
    chk("mid_rst_refill_valid", {63'd0, refill_valid}, 64'd0);
    chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
    ack(64'hDEAD);
    tick(3);
    chk("mid_rst_no_resp", 64'(resps - r0), 64'd0);
    rd_miss(29'h00000C5, 64'h66, 0);
    rd_miss(29'h0000045, 64'h67, 0);

    // Continuous request during a slow refill: stalled, then accepted once more.
    r0 = resps;
    sb.push_back('{hit: 1'b0, data: 64'hD1});
    issue(1'b0, 29'h0000009, 64'd0, 1'b1);
    wait_refill(29'h0000009);
    for (int i = 0; i < 10; i++) begin
      chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
      tick();
    end
    sb.push_back('{hit: 1'b1, data: 64'hD1});
    ack(64'hD1);
    chk("post_ack_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    tick(4);
    chk("held_req_resp_count", 64'(resps - r0), 64'd2);

    tick(3);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
